// File: rtl/ps2_move_decoder_pkg.sv
// Shared definitions for the PS/2 move decoder: move codes, set-2 scancodes,
// frame FSM states and the held-key record.
package ps2_move_decoder_pkg;

   typedef enum logic [2:0] {
      NONE  = 3'd0,
      UP    = 3'd1,
      DOWN  = 3'd2,
      LEFT  = 3'd3,
      RIGHT = 3'd4,
      RESET = 3'd5
   } move_t;

   localparam logic [7:0] SC_EXT       = 8'hE0;
   localparam logic [7:0] SC_BRK       = 8'hF0;
   localparam logic [7:0] SC_UP        = 8'h1D;
   localparam logic [7:0] SC_UP_EXT    = 8'h75;
   localparam logic [7:0] SC_DOWN      = 8'h1B;
   localparam logic [7:0] SC_DOWN_EXT  = 8'h72;
   localparam logic [7:0] SC_LEFT      = 8'h1C;
   localparam logic [7:0] SC_LEFT_EXT  = 8'h6B;
   localparam logic [7:0] SC_RIGHT     = 8'h23;
   localparam logic [7:0] SC_RIGHT_EXT = 8'h74;
   localparam logic [7:0] SC_RESET     = 8'h2D;
   localparam logic [7:0] SC_RESET_ALT = 8'h76;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } frame_state_t;

   // valid=0 encodes "no key held"
   typedef struct packed {
      logic       valid;
      logic       ext;
      logic [7:0] code;
   } held_t;

   function automatic move_t map_code(input logic ext, input logic [7:0] code);
      map_code = NONE;
      if (ext) begin
         case (code)
            SC_UP_EXT:    map_code = UP;
            SC_DOWN_EXT:  map_code = DOWN;
            SC_LEFT_EXT:  map_code = LEFT;
            SC_RIGHT_EXT: map_code = RIGHT;
            default:      map_code = NONE;
         endcase
      end else begin
         case (code)
            SC_UP:        map_code = UP;
            SC_DOWN:      map_code = DOWN;
            SC_LEFT:      map_code = LEFT;
            SC_RIGHT:     map_code = RIGHT;
            SC_RESET,
            SC_RESET_ALT: map_code = RESET;
            default:      map_code = NONE;
         endcase
      end
   endfunction

endpackage

// File: rtl/ps2_move_decoder_rx_frame.sv
// PS/2 frame receiver: input synchronizers, ps2_clk glitch filter, 11-bit frame
// FSM with odd-parity/stop checking and an intra-frame idle timeout.
module ps2_rx_frame
   import ps2_move_decoder_pkg::*;
#(
   parameter int CLK_HZ     = 100_000_000,
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT_US = 200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       frame_err
);

   localparam int TO_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
   localparam int TO_W   = $clog2(TO_CYC + 1);
   localparam int FL_W   = $clog2(FILTER_LEN + 1);

   logic              clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
   logic              filt_q, filt_d;
   logic [FL_W-1:0]   flt_cnt_q, flt_cnt_d;
   logic              fall, timeout;
   frame_state_t      state_q, state_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [7:0]        shift_q, shift_d;
   logic              par_q, par_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic              valid_q, valid_d, err_q, err_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_s1_q  <= 1'b1;
         clk_s2_q  <= 1'b1;
         dat_s1_q  <= 1'b1;
         dat_s2_q  <= 1'b1;
         filt_q    <= 1'b1;
         flt_cnt_q <= '0;
         state_q   <= ST_IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         par_q     <= 1'b0;
         to_cnt_q  <= '0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         clk_s1_q  <= ps2_clk;
         clk_s2_q  <= clk_s1_q;
         dat_s1_q  <= ps2_data;
         dat_s2_q  <= dat_s1_q;
         filt_q    <= filt_d;
         flt_cnt_q <= flt_cnt_d;
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         par_q     <= par_d;
         to_cnt_q  <= to_cnt_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
      end
   end

   // The filtered level flips only after FILTER_LEN consecutive disagreeing samples.
   always_comb begin
      filt_d    = filt_q;
      flt_cnt_d = '0;
      if (clk_s2_q != filt_q) begin
         if (flt_cnt_q == FL_W'(FILTER_LEN - 1)) filt_d = clk_s2_q;
         else flt_cnt_d = flt_cnt_q + 1'b1;
      end
      fall     = filt_q & ~filt_d;
      timeout  = (state_q != ST_IDLE) && !fall && (to_cnt_q == TO_W'(TO_CYC - 1));
      to_cnt_d = (fall || state_q == ST_IDLE) ? '0 : to_cnt_q + 1'b1;
   end

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      par_d     = par_q;
      if (timeout) begin
         state_d = ST_IDLE;
      end else if (fall) begin
         case (state_q)
            ST_IDLE: begin
               if (!dat_s2_q) begin
                  state_d   = ST_DATA;
                  bit_cnt_d = '0;
               end
            end
            ST_DATA: begin
               shift_d   = {dat_s2_q, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
            end
            ST_PARITY: begin
               par_d   = dat_s2_q;
               state_d = ST_STOP;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      valid_d = 1'b0;
      err_d   = timeout;
      if (fall && state_q == ST_STOP) begin
         if (dat_s2_q && ^{shift_q, par_q}) valid_d = 1'b1;
         else err_d = 1'b1;
      end
   end

   assign byte_valid = valid_q;
   assign byte_data  = shift_q;
   assign frame_err  = err_q;

endmodule

// File: rtl/ps2_move_decoder.sv
// PS/2 keyboard to one-cycle game move commands (set-2 scancodes).
// Define TYPEMATIC_EN to let repeated make codes of the held key move again.
module ps2_move_decoder
   import ps2_move_decoder_pkg::*;
#(
   parameter int CLK_HZ     = 100_000_000,
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT_US = 200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [2:0] move,
   output logic       frame_err
);

   logic       byte_valid;
   logic [7:0] byte_data;
   logic       rx_err;
   logic       ext_q, ext_d, brk_q, brk_d;
   held_t      held_q, held_d, cur_key;
   move_t      move_q, move_d, mapped;

   ps2_rx_frame #(
      .CLK_HZ     (CLK_HZ),
      .FILTER_LEN (FILTER_LEN),
      .TIMEOUT_US (TIMEOUT_US)
   ) u_rx (
      .clk        (clk),
      .rst        (rst),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .frame_err  (rx_err)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ext_q  <= 1'b0;
         brk_q  <= 1'b0;
         held_q <= '0;
         move_q <= NONE;
      end else begin
         ext_q  <= ext_d;
         brk_q  <= brk_d;
         held_q <= held_d;
         move_q <= move_d;
      end
   end

   always_comb begin
      ext_d   = ext_q;
      brk_d   = brk_q;
      held_d  = held_q;
      move_d  = NONE;
      cur_key = {1'b1, ext_q, byte_data};
      mapped  = map_code(ext_q, byte_data);
      if (rx_err) begin
         ext_d = 1'b0;
         brk_d = 1'b0;
      end else if (byte_valid) begin
         if (byte_data == SC_EXT) begin
            ext_d = 1'b1;
         end else if (byte_data == SC_BRK) begin
            brk_d = 1'b1;
         end else begin
            ext_d = 1'b0;
            brk_d = 1'b0;
            if (brk_q) begin
               if (held_q == cur_key) held_d = '0;
            end else if (mapped != NONE) begin
               held_d = cur_key;
`ifdef TYPEMATIC_EN
               move_d = mapped;
`else
               if (held_q != cur_key) move_d = mapped;
`endif
            end
         end
      end
   end

   assign move      = move_q;
   assign frame_err = rx_err;

endmodule

// File: doc/ps2_move_decoder.md
# ps2_move_decoder

Receives scancodes from a PS/2 keyboard and turns them into the one-cycle `move` commands consumed by the game logic block. Sits between the board's PS/2 pins and the game logic `move` input. Each qualifying key press yields exactly one non-`NONE` cycle on `move`; all other cycles drive `NONE`.

## Interface
- `CLK_HZ`, 100_000_000: system clock frequency in Hz.
- `FILTER_LEN`, 8: number of consecutive equal synchronized `ps2_clk` samples needed before the filtered level changes.
- `TIMEOUT_US`, 200: idle time within a frame after which the partial frame is discarded.

- `clk`  in  1  100 MHz system clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `ps2_clk`  in  1  raw PS/2 clock from the keyboard; asynchronous to `clk`.
- `ps2_data`  in  1  raw PS/2 data from the keyboard; asynchronous to `clk`.
- `move`  out  3  move command. Held for one cycle per press; `NONE` otherwise.
- `frame_err`  out  1  one-cycle pulse on a parity error, stop-bit error or timeout.

## Operation
- Input conditioning:
  - Both inputs pass through 2-FF synchronizers.
  - `ps2_clk` then passes through the `FILTER_LEN` glitch filter. The filtered level resets to 1.
  - An edge event is a cycle in which the filtered clock goes 1→0. The synchronized `ps2_data` is sampled in that same cycle.
- Frame FSM, states IDLE, DATA, PARITY, STOP:
  - IDLE: an edge event with data=0 moves to DATA with bit count 0. An edge event with data=1 is ignored.
  - DATA: shifts bits in LSB-first. After the 8th bit it moves to PARITY.
  - PARITY: stores the parity bit and moves to STOP.
  - STOP: returns to IDLE. The byte is valid only if data=1 and the 9 bits (8 data bits plus parity) have odd parity. Otherwise `frame_err` pulses and the byte is dropped.
- Timeout: a cycle counter is cleared on every edge event. If it reaches `CLK_HZ/1_000_000*TIMEOUT_US` while not in IDLE, the FSM returns to IDLE and `frame_err` pulses.
- Byte decoder, using set-2 scancodes:
  - Flags `ext` (E0 seen) and `brk` (F0 seen) are set by their prefix bytes.
  - Any other byte clears both flags after being decoded.
  - A byte with `brk`=1 is a release: it never produces a move.
  - Make-code mapping, with `ext` required where shown:
    - 1D or E0 75 → `UP`
    - 1B or E0 72 → `DOWN`
    - 1C or E0 6B → `LEFT`
    - 23 or E0 74 → `RIGHT`
    - 2D or 76 → `RESET`
  - Any other make code produces nothing.
- Held-key tracking:
  - Register `held` stores {ext, code} of the last mapped make code. Its reset value is "none".
  - A release matching `held` clears it.
  - A release of any other key leaves `held` unchanged.
- Boundaries:
  - A frame error clears `ext` and `brk`.
  - `rst` mid-frame returns the FSM to IDLE and clears the shift register, counters, flags and `held`.
  - A stray F0 F0 sequence keeps `brk`=1 until the next non-prefix byte.

## Timing
- Reset values: `move`=`NONE`, `frame_err`=0, FSM=IDLE, filtered clock=1.
- Latency:
  - Edge event of the stop bit in cycle N: the decoded byte is registered at N+1.
  - `move` is asserted at N+2 for exactly one cycle.
  - `frame_err` is asserted at N+1 for one cycle.
- Minimum spacing of two `move` pulses is one full PS/2 frame (more than 11 edge events). Pulses can therefore never be adjacent.
- No handshake: the consumer must sample `move` every cycle.

## Configuration
- `TYPEMATIC_EN` defined: a repeated make code equal to `held` produces a move again, so keyboard auto-repeat moves the player continuously.
- `TYPEMATIC_EN` undefined: a make code equal to `held` is suppressed. A new move for that key requires its release first. A different key is always accepted and replaces `held`.

## Structure
- Move codes live in the shared parameter file: `NONE`=0, `UP`=1, `DOWN`=2, `LEFT`=3, `RIGHT`=4, `RESET`=5.
- Scancode constants also live in the shared parameter file: `SC_EXT`=E0, `SC_BRK`=F0, and the mapped make codes.
- Sub-module `ps2_rx_frame`: synchronizers, filter, frame FSM and timeout. Outputs `byte_valid`, `byte_data[7:0]` and `frame_err`.
- The top level holds the prefix flags, `held` and the mapping.

## Test plan
- Frame 1D with correct parity → `move`=1 (`UP`) for exactly one cycle, 2 cycles after the stop-bit edge event; `NONE` otherwise.
- E0 6B, then E0 F0 6B, then E0 6B → two `LEFT` pulses; the release produces none.
- 23, 23, 23 without release → without `TYPEMATIC_EN`, one `RIGHT`; with it, three `RIGHT`.
- Frame 1B with the parity bit flipped → `frame_err` pulse, no move. The following good 1B → `DOWN`.
- Start bit plus 4 data bits, then silence beyond 200 µs → `frame_err`, FSM back in IDLE. A subsequent 76 → `RESET`.
- `rst` asserted after the 5th bit of 2D → no move, no `frame_err`. The next complete 2D → `RESET`.
